// File: rtl/controlmux.sv
// controlmux: select for the ID_EX control mux, zero inserts a bubble
package controlmux;
  typedef enum logic {normal, zero} controlmux_sel_t;
endpackage

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline stall/freeze control for load-use and decode-stage branch hazards
module hazard_stall_unit (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4:0]                  ID_rs1_i,
  input  logic [4:0]                  ID_rs2_i,
  input  logic                        ID_uses_rs1_i,
  input  logic                        ID_uses_rs2_i,
  input  logic                        ID_is_br_i,
  input  logic [4:0]                  ID_EX_rd_i,
  input  logic                        ID_EX_load_regfile_i,
  input  logic                        ID_EX_is_load_i,
  input  logic [4:0]                  EX_MEM_rd_i,
  input  logic                        EX_MEM_load_regfile_i,
  input  logic                        EX_MEM_is_load_i,
  input  logic                        icache_resp_i,
  input  logic                        dcache_req_i,
  input  logic                        dcache_resp_i,
  input  logic                        flush_i,
  output logic                        load_pc_o,
  output logic                        IF_ID_load_o,
  output logic                        ID_EX_load_o,
  output logic                        EX_MEM_load_o,
  output logic                        MEM_WB_load_o,
  output controlmux::controlmux_sel_t controlmux_sel_o,
  output logic                        stall_br_haz1_o,
  output logic                        stall_br_haz2_o,
  output logic [31:0]                 stall_cycles_o,
  output logic [15:0]                 hazard_events_o
);
  typedef enum logic {RUN, BR_LAST} state_t;
  state_t state, state_nx;
  logic freeze, m_ex, m_mem, lu, br1, br2, stall, det;
  assign freeze = (dcache_req_i & ~dcache_resp_i) | ~icache_resp_i;
  assign m_ex = (ID_uses_rs1_i & |ID_EX_rd_i & (ID_EX_rd_i == ID_rs1_i)) |
                (ID_uses_rs2_i & |ID_EX_rd_i & (ID_EX_rd_i == ID_rs2_i));
  assign m_mem = (ID_uses_rs1_i & |EX_MEM_rd_i & (EX_MEM_rd_i == ID_rs1_i)) |
                 (ID_uses_rs2_i & |EX_MEM_rd_i & (EX_MEM_rd_i == ID_rs2_i));
  assign lu = ID_EX_load_regfile_i & ID_EX_is_load_i & m_ex & ~ID_is_br_i;
  assign br2 = ID_is_br_i & ID_EX_load_regfile_i & ID_EX_is_load_i & m_ex;
  assign br1 = ID_is_br_i & ~br2 & ((ID_EX_load_regfile_i & m_ex) |
               (EX_MEM_load_regfile_i & EX_MEM_is_load_i & m_mem));
  // next state and enables: reset/freeze hold everything, flush wins over stalls, BR_LAST over detection
  always_comb begin
    {load_pc_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o} = 5'b11111;
    controlmux_sel_o = controlmux::normal;
    stall_br_haz1_o = 1'b0;
    stall_br_haz2_o = 1'b0;
    state_nx = state;
    stall = 1'b0;
    det = 1'b0;
    if (!rst || freeze) begin
      {load_pc_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o} = 5'b00000;
      state_nx = rst ? state : RUN;
    end else if (flush_i) begin
      state_nx = RUN;
    end else if (state == BR_LAST || lu || br1 || br2) begin
      {load_pc_o, IF_ID_load_o} = 2'b00;
      controlmux_sel_o = controlmux::zero;
      stall = 1'b1;
      det = state == RUN;
      stall_br_haz1_o = state == BR_LAST || br1;
      stall_br_haz2_o = state == RUN && br2;
      state_nx = (state == RUN && br2) ? BR_LAST : RUN;
    end
  end
  // state register and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      stall_cycles_o <= '0;
      hazard_events_o <= '0;
    end else begin
      state <= state_nx;
      if ((freeze | stall) & ~&stall_cycles_o) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (det & ~&hazard_events_o) hazard_events_o <= hazard_events_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random checks of hazard_stall_unit against a stall-count model
module tb_hazard_stall_unit;
  logic clk, rst;
  logic [4:0] ID_rs1_i, ID_rs2_i, ID_EX_rd_i, EX_MEM_rd_i;
  logic ID_uses_rs1_i, ID_uses_rs2_i, ID_is_br_i;
  logic ID_EX_load_regfile_i, ID_EX_is_load_i, EX_MEM_load_regfile_i, EX_MEM_is_load_i;
  logic icache_resp_i, dcache_req_i, dcache_resp_i, flush_i;
  logic load_pc_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o;
  controlmux::controlmux_sel_t controlmux_sel_o;
  logic stall_br_haz1_o, stall_br_haz2_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] hazard_events_o;
  int checks = 0, failures = 0;
  int pend, npend, kind;
  logic [31:0] mst, nst;
  logic [15:0] mev, nev;
  logic [7:0] e;
  logic fz, exh, memh, h1, h2;
  localparam logic [7:0] NORMAL = 8'b11111_0_00;
  localparam logic [7:0] FROZEN = 8'b00000_0_00;
  localparam logic [7:0] ST_H1 = 8'b00111_1_10;
  localparam logic [7:0] ST_H2 = 8'b00111_1_01;
  localparam logic [7:0] ST_LU = 8'b00111_1_00;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i), .ID_is_br_i(ID_is_br_i),
    .ID_EX_rd_i(ID_EX_rd_i), .ID_EX_load_regfile_i(ID_EX_load_regfile_i), .ID_EX_is_load_i(ID_EX_is_load_i),
    .EX_MEM_rd_i(EX_MEM_rd_i), .EX_MEM_load_regfile_i(EX_MEM_load_regfile_i), .EX_MEM_is_load_i(EX_MEM_is_load_i),
    .icache_resp_i(icache_resp_i), .dcache_req_i(dcache_req_i), .dcache_resp_i(dcache_resp_i),
    .flush_i(flush_i),
    .load_pc_o(load_pc_o), .IF_ID_load_o(IF_ID_load_o), .ID_EX_load_o(ID_EX_load_o),
    .EX_MEM_load_o(EX_MEM_load_o), .MEM_WB_load_o(MEM_WB_load_o),
    .controlmux_sel_o(controlmux_sel_o),
    .stall_br_haz1_o(stall_br_haz1_o), .stall_br_haz2_o(stall_br_haz2_o),
    .stall_cycles_o(stall_cycles_o), .hazard_events_o(hazard_events_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs, input logic u);
    return u && rd != 5'd0 && rd == rs;
  endfunction

  function automatic logic [7:0] outs();
    return {load_pc_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
            controlmux_sel_o == controlmux::zero, stall_br_haz1_o, stall_br_haz2_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    {ID_rs1_i, ID_rs2_i, ID_EX_rd_i, EX_MEM_rd_i} = '0;
    {ID_uses_rs1_i, ID_uses_rs2_i, ID_is_br_i} = '0;
    {ID_EX_load_regfile_i, ID_EX_is_load_i, EX_MEM_load_regfile_i, EX_MEM_is_load_i} = '0;
    icache_resp_i = 1'b1;
    dcache_req_i = 1'b0;
    dcache_resp_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic load_producer(input logic br);
    idle();
    ID_EX_rd_i = 5'd5;
    ID_EX_load_regfile_i = 1'b1;
    ID_EX_is_load_i = 1'b1;
    ID_rs1_i = 5'd5;
    ID_uses_rs1_i = 1'b1;
    ID_is_br_i = br;
  endtask

  task automatic randomize_inputs();
    ID_rs1_i = 5'($urandom_range(0, 3));
    ID_rs2_i = 5'($urandom_range(0, 3));
    ID_EX_rd_i = 5'($urandom_range(0, 3));
    EX_MEM_rd_i = 5'($urandom_range(0, 3));
    ID_uses_rs1_i = 1'($urandom_range(0, 1));
    ID_uses_rs2_i = 1'($urandom_range(0, 1));
    ID_is_br_i = 1'($urandom_range(0, 1));
    ID_EX_load_regfile_i = 1'($urandom_range(0, 1));
    ID_EX_is_load_i = 1'($urandom_range(0, 1));
    EX_MEM_load_regfile_i = 1'($urandom_range(0, 1));
    EX_MEM_is_load_i = 1'($urandom_range(0, 1));
    icache_resp_i = $urandom_range(0, 9) != 0;
    dcache_req_i = $urandom_range(0, 3) == 0;
    dcache_resp_i = 1'($urandom_range(0, 1));
    flush_i = $urandom_range(0, 9) == 0;
    rst = $urandom_range(0, 49) != 0;
  endtask

  // reference model: remaining branch stalls plus counter values, checked every cycle
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0;
      mst = '0;
      mev = '0;
    end
    fz = (dcache_req_i & ~dcache_resp_i) | ~icache_resp_i;
    exh = hit(ID_EX_rd_i, ID_rs1_i, ID_uses_rs1_i) | hit(ID_EX_rd_i, ID_rs2_i, ID_uses_rs2_i);
    memh = hit(EX_MEM_rd_i, ID_rs1_i, ID_uses_rs1_i) | hit(EX_MEM_rd_i, ID_rs2_i, ID_uses_rs2_i);
    kind = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    if (ID_is_br_i) begin
      if (ID_EX_load_regfile_i && ID_EX_is_load_i && exh) begin
        kind = 2;
        h2 = 1'b1;
      end else if ((ID_EX_load_regfile_i && exh) || (EX_MEM_load_regfile_i && EX_MEM_is_load_i && memh)) begin
        kind = 1;
        h1 = 1'b1;
      end
    end else if (ID_EX_load_regfile_i && ID_EX_is_load_i && exh) kind = 1;
    npend = pend;
    nst = (mst == 32'hFFFF_FFFF) ? mst : mst + 32'd1;
    nev = mev;
    if (!rst) begin
      e = FROZEN;
      nst = mst;
    end else if (fz) e = FROZEN;
    else if (flush_i) begin
      e = NORMAL;
      npend = 0;
      nst = mst;
    end else if (pend > 0) begin
      e = ST_H1;
      npend = pend - 1;
    end else if (kind > 0) begin
      e = {5'b00111, 1'b1, h1, h2};
      npend = kind - 1;
      nev = (mev == 16'hFFFF) ? mev : mev + 16'd1;
    end else begin
      e = NORMAL;
      nst = mst;
    end
    chk("outputs", 32'(outs()), 32'(e));
    chk("stall_cycles", stall_cycles_o, mst);
    chk("hazard_events", 32'(hazard_events_o), 32'(mev));
    chk("haz_exclusive", 32'(stall_br_haz1_o & stall_br_haz2_o), 32'd0);
    pend = npend;
    mst = nst;
    mev = nev;
  end

  initial begin
    rst = 1'b0;
    idle();
    look();
    chk("reset_outs", 32'(outs()), 32'(FROZEN));
    chk("reset_stall_cnt", stall_cycles_o, 32'd0);
    chk("reset_ev_cnt", 32'(hazard_events_o), 32'd0);
    tick();
    rst = 1'b1;
    look();
    chk("run_normal", 32'(outs()), 32'(NORMAL));
    tick();
    load_producer(1'b0);
    look();
    chk("lu_stall", 32'(outs()), 32'(ST_LU));
    tick();
    idle();
    look();
    chk("lu_after", 32'(outs()), 32'(NORMAL));
    chk("lu_events", 32'(hazard_events_o), 32'd1);
    chk("lu_stalls", stall_cycles_o, 32'd1);
    tick();
    load_producer(1'b1);
    look();
    chk("brld_c1", 32'(outs()), 32'(ST_H2));
    tick();
    idle();
    look();
    chk("brld_c2", 32'(outs()), 32'(ST_H1));
    tick();
    look();
    chk("brld_c3", 32'(outs()), 32'(NORMAL));
    chk("brld_stalls", stall_cycles_o, 32'd3);
    tick();
    ID_EX_rd_i = 5'd7;
    ID_EX_load_regfile_i = 1'b1;
    ID_is_br_i = 1'b1;
    ID_rs2_i = 5'd7;
    ID_uses_rs2_i = 1'b1;
    look();
    chk("bralu_stall", 32'(outs()), 32'(ST_H1));
    tick();
    ID_EX_rd_i = 5'd0;
    ID_rs2_i = 5'd0;
    look();
    chk("x0_nostall", 32'(outs()), 32'(NORMAL));
    chk("x0_events", 32'(hazard_events_o), 32'd3);
    tick();
    load_producer(1'b1);
    look();
    chk("frz_c1", 32'(outs()), 32'(ST_H2));
    tick();
    idle();
    dcache_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("frz_hold", 32'(outs()), 32'(FROZEN));
      tick();
      if (i == 2) dcache_req_i = 1'b0;
    end
    look();
    chk("frz_brlast", 32'(outs()), 32'(ST_H1));
    tick();
    look();
    chk("frz_after", 32'(outs()), 32'(NORMAL));
    chk("frz_stalls", stall_cycles_o, 32'd9);
    tick();
    load_producer(1'b0);
    flush_i = 1'b1;
    look();
    chk("flush_nostall", 32'(outs()), 32'(NORMAL));
    tick();
    idle();
    look();
    chk("flush_events", 32'(hazard_events_o), 32'd4);
    for (int i = 0; i < 3000; i++) begin
      tick();
      randomize_inputs();
    end
    tick();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    load_producer(1'b0);
    repeat (65540) tick();
    look();
    chk("ev_saturated", 32'(hazard_events_o), 32'h0000_FFFF);
    tick();
    load_producer(1'b1);
    look();
    chk("sat_br_c1", 32'(outs()), 32'(ST_H2));
    tick();
    idle();
    look();
    chk("sat_br_c2", 32'(outs()), 32'(ST_H1));
    rst = 1'b0;
    #1;
    chk("rst_outs", 32'(outs()), 32'(FROZEN));
    chk("rst_stall_cnt", stall_cycles_o, 32'd0);
    chk("rst_ev_cnt", 32'(hazard_events_o), 32'd0);
    tick();
    look();
    tick();
    rst = 1'b1;
    look();
    chk("rst_release_run", 32'(outs()), 32'(NORMAL));
    chk("rst_release_cnt", stall_cycles_o, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
